// File: rtl/glb_wght_responder.sv
// ---------------------------------------------------------------------------
// glb_wght_responder
//
// Global weight buffer with a small fill/serve controller. A fill phase
// writes weight words into an on-chip array. The controller then serves
// single-cycle read requests from the weight router until it is flushed.
//
// Build option:
//   GLB_WGHT_OUTREG_EN - when defined, r_data/r_valid/r_err pass through one
//                        extra register stage (read latency 2 instead of 1,
//                        same throughput).
//
// Parameters:
//   DATA_BITWIDTH     - width of a weight word
//   ADDR_BITWIDTH_GLB - buffer address width; depth is 2**ADDR_BITWIDTH_GLB
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous active-high reset (memory is not cleared)
//   write_en  - fill-side write strobe
//   w_addr    - fill write address
//   w_data    - fill write data (signed)
//   fill_done - one-cycle pulse ending the fill phase
//   flush     - one-cycle pulse returning the block to IDLE
//   read_req  - read request from the weight router
//   r_addr    - read address from the weight router
//   r_data    - read data (holds its last value when no read returns)
//   r_valid   - r_data qualifier
//   ready     - high only while serving reads
//   r_err     - one-cycle pulse for a read request made outside READY
//   wr_count  - words written since entering FILL (saturating)
// ---------------------------------------------------------------------------
module glb_wght_responder #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_en,
  input  logic        [ADDR_BITWIDTH_GLB-1:0] w_addr,
  input  logic signed [DATA_BITWIDTH-1:0]     w_data,
  input  logic                                fill_done,
  input  logic                                flush,
  input  logic                                read_req,
  input  logic        [ADDR_BITWIDTH_GLB-1:0] r_addr,
  output logic signed [DATA_BITWIDTH-1:0]     r_data,
  output logic                                r_valid,
  output logic                                ready,
  output logic                                r_err,
  output logic        [ADDR_BITWIDTH_GLB:0]   wr_count
);

  localparam int DEPTH = 2 ** ADDR_BITWIDTH_GLB;
  localparam logic [ADDR_BITWIDTH_GLB:0] CNT_MAX = {1'b1, {ADDR_BITWIDTH_GLB{1'b0}}};
  localparam logic [ADDR_BITWIDTH_GLB:0] CNT_ONE = {{ADDR_BITWIDTH_GLB{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDR_BITWIDTH_GLB:0]     wr_count_q, wr_count_d;
  logic                           mem_we;

  logic signed [DATA_BITWIDTH-1:0] mem [DEPTH];

  logic                            rd_fire;
  logic signed [DATA_BITWIDTH-1:0] rd_data_q, rd_data_d;
  logic                            rd_valid_q, rd_valid_d;
  logic                            rd_err_q, rd_err_d;

  // Flush dominates everything else in the cycle, including a fill write.
  // The IDLE->FILL write counts as the first word.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      wr_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (write_en) begin
            mem_we     = 1'b1;
            wr_count_d = CNT_ONE;
            state_d    = FILL;
          end
        end
        FILL: begin
          if (write_en) begin
            mem_we = 1'b1;
            if (wr_count_q != CNT_MAX) begin
              wr_count_d = wr_count_q + CNT_ONE;
            end
          end
          if (fill_done) begin
            state_d = READY;
          end
        end
        READY: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Reads are judged on the current state, so a request that coincides with
  // flush in READY is still served.
  always_comb begin
    rd_fire    = read_req && (state_q == READY);
    rd_valid_d = rd_fire;
    rd_err_d   = read_req && (state_q != READY);
    rd_data_d  = rd_fire ? mem[r_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Storage array has no reset so weights survive reset and flush.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[w_addr] <= w_data;
    end
  end

  assign ready    = (state_q == READY);
  assign wr_count = wr_count_q;

`ifdef GLB_WGHT_OUTREG_EN
  logic signed [DATA_BITWIDTH-1:0] out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_err_q, out_err_d;

  always_comb begin
    out_data_d  = rd_data_q;
    out_valid_d = rd_valid_q;
    out_err_d   = rd_err_q;
  end

  // Reset clears both stages so a read in flight never emerges.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign r_data  = out_data_q;
  assign r_valid = out_valid_q;
  assign r_err   = out_err_q;
`else
  assign r_data  = rd_data_q;
  assign r_valid = rd_valid_q;
  assign r_err   = rd_err_q;
`endif

endmodule
